// File: rtl/common.sv
// Shared CNF types and literal helpers for the DPLL datapath.
// Combinational helpers only; no latency, no flow control.
package common;
  localparam int number_clauses    = 4;
  localparam int number_lits       = 3;
  localparam int width_clausearray = 2;
  localparam int width_litarray    = 2;
  localparam int width_var         = 4;

  typedef struct packed {
    logic                 neg;
    logic [width_var-1:0] id;
  } lit;

  typedef struct packed {
    logic [width_litarray:0] len;
    lit [number_lits-1:0]    lits;
  } clause;

  typedef struct packed {
    logic [width_clausearray:0]  len;
    clause [number_clauses-1:0]  clauses;
  } formula;

  typedef logic [width_clausearray:0] clause_idx_t;
  typedef logic [width_litarray:0]    lit_cnt_t;

  localparam lit          zero_lit     = '0;
  localparam clause       zero_clause  = '0;
  localparam formula      zero_formula = '0;
  localparam clause_idx_t clause_limit = clause_idx_t'(number_clauses);

  function automatic lit lit_complement(lit l);
    lit r;
    r     = l;
    r.neg = ~l.neg;
    return r;
  endfunction

  function automatic logic lit_equal(lit a, lit b);
    return (a.neg == b.neg) && (a.id == b.id);
  endfunction
endpackage

// File: rtl/clause_reduce.sv
// Applies one literal to one clause: reports satisfaction, drops complements and compacts survivors.
// Purely combinational, no flow control.
module clause_reduce
  import common::*;
(
  input  logic  [0:0] unused_tie,
  input  clause       in_clause,
  input  lit          in_lit,
  output logic        satisfied,
  output clause       reduced,
  output logic        shrunk
);
  lit       neg_lit;
  lit_cnt_t cnt;

  assign neg_lit = lit_complement(in_lit);

  always_comb begin
    satisfied = 1'b0;
    reduced   = zero_clause;
    cnt       = '0;
    for (int k = 0; k < number_lits; k++) begin
      if (k < int'(in_clause.len)) begin
        if (lit_equal(in_clause.lits[k], in_lit)) begin
          satisfied = 1'b1;
        end else if (!lit_equal(in_clause.lits[k], neg_lit)) begin
          // cnt never exceeds k here, so the write stays inside lits[]
          reduced.lits[cnt[width_litarray-1:0]] = in_clause.lits[k];
          cnt = cnt + lit_cnt_t'(1);
        end
      end
    end
    reduced.len = cnt;
  end

  assign shrunk = !satisfied && (reduced.len < in_clause.len) && (unused_tie == 1'b0);
endmodule

// File: rtl/literal_assign.sv
// Simplifies a CNF formula by one decided literal, one clause per cycle; ended at t+1+N, or at the conflicting clause.
// No backpressure: apply is taken only when idle; optional counters under ASSIGN_STATS_EN.
module literal_assign
  import common::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   apply,
  input  formula in_formula,
  input  lit     in_lit,
  output logic   busy,
  output logic   ended,
  output logic   conflict,
  output formula out_formula
`ifdef ASSIGN_STATS_EN
  ,
  output logic [width_clausearray:0] stat_sat,
  output logic [width_clausearray:0] stat_shrunk
`endif
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state;
  formula      s_formula;
  lit          s_lit;
  clause_idx_t i;
  clause_idx_t j;
  logic        satisfied;
  logic        shrunk;
  clause       reduced;

  clause_reduce u_reduce (
    .unused_tie (1'b0),
    .in_clause  (s_formula.clauses[i[width_clausearray-1:0]]),
    .in_lit     (s_lit),
    .satisfied  (satisfied),
    .reduced    (reduced),
    .shrunk     (shrunk)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      ended       <= 1'b0;
      conflict    <= 1'b0;
      out_formula <= zero_formula;
      s_formula   <= zero_formula;
      s_lit       <= zero_lit;
      i           <= '0;
      j           <= '0;
`ifdef ASSIGN_STATS_EN
      stat_sat    <= '0;
      stat_shrunk <= '0;
`endif
    end else begin
      ended <= 1'b0;
      case (state)
        IDLE: begin
          if (apply) begin
            s_formula   <= in_formula;
            s_lit       <= in_lit;
            out_formula <= zero_formula;
            conflict    <= 1'b0;
            i           <= '0;
            j           <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
`ifdef ASSIGN_STATS_EN
            stat_sat    <= '0;
            stat_shrunk <= '0;
`endif
          end
        end
        SCAN: begin
          if ((i < s_formula.len) && (i < clause_limit)) begin
            i <= i + clause_idx_t'(1);
`ifdef ASSIGN_STATS_EN
            if (satisfied) stat_sat <= stat_sat + clause_idx_t'(1);
            if (shrunk) stat_shrunk <= stat_shrunk + clause_idx_t'(1);
`endif
            if (!satisfied) begin
              // an emptied clause ends the scan; out_formula.len stays 0
              if (reduced.len == '0) begin
                conflict <= 1'b1;
                ended    <= 1'b1;
                busy     <= 1'b0;
                state    <= IDLE;
              end else begin
                out_formula.clauses[j[width_clausearray-1:0]] <= reduced;
                j <= j + clause_idx_t'(1);
              end
            end
          end else begin
            out_formula.len <= j;
            ended           <= 1'b1;
            conflict        <= 1'b0;
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_literal_assign.sv
// Directed bench for literal_assign: hand-computed formulas, latency and reset abort.
module tb_literal_assign;
  import common::*;

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  logic   apply = 1'b0;
  formula in_formula = '0;
  lit     in_lit = '0;
  logic   busy, ended, conflict;
  formula out_formula;
`ifdef ASSIGN_STATS_EN
  logic [width_clausearray:0] stat_sat, stat_shrunk;
`endif

  int checks = 0;
  int passes = 0;

  literal_assign dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .apply       (apply),
    .in_formula  (in_formula),
    .in_lit      (in_lit),
    .busy        (busy),
    .ended       (ended),
    .conflict    (conflict),
    .out_formula (out_formula)
`ifdef ASSIGN_STATS_EN
    ,
    .stat_sat    (stat_sat),
    .stat_shrunk (stat_shrunk)
`endif
  );

  always #5 clock = ~clock;

  function automatic lit mkl(int v);
    lit l;
    l.neg = (v < 0);
    l.id  = width_var'((v < 0) ? -v : v);
    return l;
  endfunction

  function automatic clause mkc(int n, int a = 0, int b = 0, int c = 0);
    clause r;
    r.len     = lit_cnt_t'(n);
    r.lits[0] = mkl(a);
    r.lits[1] = mkl(b);
    r.lits[2] = mkl(c);
    return r;
  endfunction

  // Accept at edge t, then return n such that ended is seen after edge t+n (-1 on timeout).
  task automatic run_apply(input formula f, input lit l, output int n);
    @(negedge clock);
    in_formula = f;
    in_lit     = l;
    apply      = 1'b1;
    @(posedge clock);
    #1 apply = 1'b0;
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (ended) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({busy, ended, conflict} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, ended, conflict}); else passes++;
    checks++; if (out_formula !== zero_formula) $display("FAIL reset_formula: got %h want 0", out_formula); else passes++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    formula f, e;
    int n;
    f = '0; e = '0;
    f.len = 3; f.clauses[0] = mkc(2, 1, 2); f.clauses[1] = mkc(2, -1, 3); f.clauses[2] = mkc(1, 4);
    e.len = 2; e.clauses[0] = mkc(1, 3); e.clauses[1] = mkc(1, 4);
    run_apply(f, mkl(1), n);
    checks++; if (n !== 4) $display("FAIL basic_latency: got %0d want 4", n); else passes++;
    checks++; if (out_formula !== e) $display("FAIL basic_formula: got %h want %h", out_formula, e); else passes++;
    checks++; if ({busy, conflict} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {busy, conflict}); else passes++;
`ifdef ASSIGN_STATS_EN
    checks++; if ({stat_sat, stat_shrunk} !== {3'd1, 3'd1}) $display("FAIL basic_stats: got %0d/%0d want 1/1", stat_sat, stat_shrunk); else passes++;
`endif
    @(posedge clock); #1;
    checks++; if (ended !== 1'b0) $display("FAIL basic_pulse: got %b want 0", ended); else passes++;
  endtask

  task automatic test_conflict();
    formula f, e;
    int n;
    f = '0; e = '0;
    f.len = 2; f.clauses[0] = mkc(1, -2); f.clauses[1] = mkc(2, 2, 5);
    run_apply(f, mkl(2), n);
    checks++; if (n !== 1) $display("FAIL conflict0_latency: got %0d want 1", n); else passes++;
    checks++; if (conflict !== 1'b1) $display("FAIL conflict0_flag: got %b want 1", conflict); else passes++;
    checks++; if (out_formula !== e) $display("FAIL conflict0_formula: got %h want %h", out_formula, e); else passes++;
    // conflict on the third clause keeps the two clauses already written
    f = '0;
    f.len = 4; f.clauses[0] = mkc(1, 1); f.clauses[1] = mkc(1, 2); f.clauses[2] = mkc(1, -3); f.clauses[3] = mkc(1, 4);
    e.clauses[0] = mkc(1, 1); e.clauses[1] = mkc(1, 2);
    run_apply(f, mkl(3), n);
    checks++; if (n !== 3) $display("FAIL conflict2_latency: got %0d want 3", n); else passes++;
    checks++; if (conflict !== 1'b1) $display("FAIL conflict2_flag: got %b want 1", conflict); else passes++;
    checks++; if (out_formula !== e) $display("FAIL conflict2_formula: got %h want %h", out_formula, e); else passes++;
  endtask

  task automatic test_empty();
    int n;
    run_apply(zero_formula, mkl(7), n);
    checks++; if (n !== 1) $display("FAIL empty_latency: got %0d want 1", n); else passes++;
    checks++; if (conflict !== 1'b0) $display("FAIL empty_conflict: got %b want 0", conflict); else passes++;
    checks++; if (out_formula !== zero_formula) $display("FAIL empty_formula: got %h want 0", out_formula); else passes++;
  endtask

  task automatic test_full();
    formula f;
    int n;
    f = '0;
    f.len = 4; f.clauses[0] = mkc(1, 1); f.clauses[1] = mkc(2, 2, 3);
    f.clauses[2] = mkc(3, 4, 5, 1); f.clauses[3] = mkc(2, -1, -2);
    run_apply(f, mkl(-6), n);
    checks++; if (n !== 5) $display("FAIL full_latency: got %0d want 5", n); else passes++;
    checks++; if (out_formula !== f) $display("FAIL full_formula: got %h want %h", out_formula, f); else passes++;
    // a length beyond the clause array is clamped to number_clauses
    f.len = 7;
    run_apply(f, mkl(6), n);
    f.len = 4;
    checks++; if (n !== 5) $display("FAIL clamp_latency: got %0d want 5", n); else passes++;
    checks++; if (out_formula !== f) $display("FAIL clamp_formula: got %h want %h", out_formula, f); else passes++;
  endtask

  task automatic test_duplicate();
    formula f, e;
    int n;
    f = '0; e = '0;
    f.len = 1; f.clauses[0] = mkc(3, -3, 1, -3);
    e.len = 1; e.clauses[0] = mkc(1, 1);
    run_apply(f, mkl(3), n);
    checks++; if (n !== 2) $display("FAIL dup_latency: got %0d want 2", n); else passes++;
    checks++; if (out_formula !== e) $display("FAIL dup_formula: got %h want %h", out_formula, e); else passes++;
    f.clauses[0] = mkc(3, 2, 2, 5);
    run_apply(f, mkl(2), n);
    checks++; if (out_formula !== zero_formula) $display("FAIL dup_sat_formula: got %h want 0", out_formula); else passes++;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    in_formula = zero_formula;
    in_lit     = mkl(7);
    apply      = 1'b1;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy got %b want 1", busy); else passes++;
    @(posedge clock); #1;
    checks++; if ({ended, busy} !== 2'b10) $display("FAIL b2b_end: ended,busy got %b want 10", {ended, busy}); else passes++;
    @(posedge clock); #1;
    checks++; if ({ended, busy} !== 2'b01) $display("FAIL b2b_restart: ended,busy got %b want 01", {ended, busy}); else passes++;
    apply = 1'b0;
    @(posedge clock); #1;
    checks++; if (ended !== 1'b1) $display("FAIL b2b_second_end: got %b want 1", ended); else passes++;
  endtask

  task automatic test_abort();
    formula f, g;
    int seen;
    f = '0; g = '0;
    f.len = 4; f.clauses[0] = mkc(1, 1); f.clauses[1] = mkc(2, 2, 3);
    f.clauses[2] = mkc(1, 4); f.clauses[3] = mkc(1, 5);
    g.len = 2; g.clauses[0] = mkc(1, 9); g.clauses[1] = mkc(1, 10);
    @(negedge clock);
    in_formula = f; in_lit = mkl(6); apply = 1'b1;
    @(posedge clock);
    #1 apply = 1'b0;
    @(negedge clock);
    in_formula = g; in_lit = mkl(9); apply = 1'b1;
    @(posedge clock);
    #1 apply = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else passes++;
    checks++; if (out_formula.clauses[1] !== f.clauses[1]) $display("FAIL abort_ignore: got %h want %h", out_formula.clauses[1], f.clauses[1]); else passes++;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if ({busy, ended, conflict} !== 3'b000) $display("FAIL abort_flags: got %b want 000", {busy, ended, conflict}); else passes++;
    checks++; if (out_formula !== zero_formula) $display("FAIL abort_formula: got %h want 0", out_formula); else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      if (ended || busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL abort_no_end: active cycles got %0d want 0", seen); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_empty();
    test_full();
    test_duplicate();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/literal_assign.md
# literal_assign

Applies one decided literal to a CNF formula: drops every clause the literal satisfies, removes the complementary literal from the remaining clauses, and compacts the result into a new formula. It sits downstream of the unit-clause finder in the DPLL datapath. It consumes the `lit` that block reports and returns the simplified `formula` plus a conflict flag to the search controller. It scans one clause per cycle, using the same start/ended handshake style as the finder.

## Interface
- No module parameters; sizes come from `common` (`number_clauses`, `number_lits`, `width_clausearray`).
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `apply` in 1: start request; sampled only when idle.
- `in_formula` in `formula`: formula to simplify; captured on an accepted `apply`.
- `in_lit` in `lit`: literal made true; captured with `in_formula`.
- `busy` out 1: high from the cycle after acceptance until `ended`.
- `ended` out 1: one-cycle completion pulse.
- `conflict` out 1: an empty clause was produced or found; held until the next accept.
- `out_formula` out `formula`: simplified formula; valid when `ended`, held until the next accept.
- `stat_sat` out `width_clausearray+1`: clauses dropped (only with `ASSIGN_STATS_EN`).
- `stat_shrunk` out `width_clausearray+1`: clauses shortened (only with `ASSIGN_STATS_EN`).

## Operation
- States: IDLE and SCAN.
- IDLE, `apply`=1: capture `in_formula` and `in_lit`, clear `out_formula` to `zero_formula`, clear `conflict`, set i=0 and j=0, go to SCAN.
- SCAN, i < `s_formula.len` and i < `number_clauses`: examine clause i. Only lits[0..len-1] are considered.
  - If any literal equals `in_lit` (same variable, same polarity): the clause is satisfied and dropped; j is unchanged.
  - Otherwise delete every literal complementary to `in_lit`, compacting the survivors in order to lits[0..k-1] and zero-filling the rest; new len = k.
  - If k=0, including an input clause with len 0: set `conflict`=1 and `ended`=1, return to IDLE, and stop the scan. `out_formula` then holds the clauses written so far.
  - If k>0: write the clause to `out_formula.clauses[j]`, then j++.
  - i++ in every case.
- SCAN, i reaches the limit: `out_formula.len` = j, `ended`=1, `conflict`=0, return to IDLE.
- Duplicate literals: the clause is satisfied if any copy matches; all complementary copies are removed.
- Arithmetic: i and j are `width_clausearray+1` bits wide, so the counters never wrap at `number_clauses`.
- `apply` while busy is ignored; `apply` held high in the same cycle `ended` pulses does not restart.

## Timing
- Reset values: `busy`=0, `ended`=0, `conflict`=0, `out_formula`=`zero_formula`, stats=0, state IDLE.
- `apply` is accepted at edge t. Clause i is processed at edge t+1+i.
- With no conflict and N = min(len, `number_clauses`) clauses, `ended` rises at edge t+1+N. For an empty formula that is edge t+1.
- On conflict at clause i, `ended` rises at edge t+1+i.
- A new `apply` is accepted no earlier than the edge after `ended`.
- `reset_n` low mid-scan aborts immediately: all outputs return to their reset values and no `ended` pulse is produced.

## Configuration
- With `ASSIGN_STATS_EN` defined, `stat_sat` and `stat_shrunk` exist. Both clear on accept, increment per clause during SCAN, and are valid with `ended`.
- Without `ASSIGN_STATS_EN`, those ports and counters are absent; all other behaviour is identical.

## Structure
- `common` supplies `lit`, `clause`, `formula`, `zero_lit`, `zero_formula`, `number_clauses`, `number_lits` and `width_clausearray`.
- Add to `common`: a `lit_complement(lit)` function and a `lit_equal(lit, lit)` function.
- Sub-module `clause_reduce` is combinational. It takes a clause and a literal and returns `satisfied`, the reduced clause, and `shrunk`. The FSM in `literal_assign` instantiates it once.

## Test plan
- {(1,2),(-1,3),(4)} with lit 1 → {(3),(4)}, conflict=0, `ended` at edge t+4; with stats: sat=1, shrunk=1.
- {(-2),(2,5)} with lit 2 → conflict=1, `ended` at edge t+1, `out_formula.len`=0.
- Empty formula with lit 7 → `ended` at edge t+1, len=0, conflict=0.
- `number_clauses` clauses, none containing ±v → output equals input, `ended` at edge t+1+`number_clauses`.
- `apply` pulsed during SCAN and `reset_n` dropped mid-scan → the second `apply` is ignored; after reset all outputs are zero with no `ended` pulse.
- Clause (-3,1,-3) with lit 3 → clause becomes (1) with lits[1..]=`zero_lit`.
